// File: rtl/evm_pkg.sv
// Shared definitions for the EVM button front end: edge-mode encodings and
// the per-channel edge qualification helper.
package evm_pkg;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;
  localparam logic [1:0] EDGE_OFF  = 2'b11;

  // Decide whether an accepted raw transition counts as an event in this mode.
  function automatic logic edge_qualify(input logic [1:0] mode_i,
                                        input logic       rise_i,
                                        input logic       fall_i);
    case (mode_i)
      EDGE_RISE: return rise_i;
      EDGE_FALL: return fall_i;
      EDGE_BOTH: return rise_i | fall_i;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One input channel: two-flop synchroniser, debounce counter and the accepted
// stable level. rise_o/fall_o strobe combinationally in the cycle whose clock
// edge commits a new stable value, so the caller can register them alongside it.
module debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  // Count consecutive cycles the synchronised input disagrees with the stable
  // level; any agreement restarts the count, the last count commits the change.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    accept   = (s2_q != stable_q) && (cnt_q == CNT_LAST);
    if (s2_q != stable_q) begin
      if (accept) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser, counter and stable level; reset discards any pending change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= in_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = accept & s2_q;
  assign fall_o   = accept & ~s2_q;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel debounced edge detector with lowest-index event reporting.
// Build option EDGE_CONFLICT_GUARD_EN: when defined, a cycle in which more than
// one channel raises a qualified edge emits no pulses and flags conflict
// instead (one vote per press); when undefined, conflict is tied low.
module multi_edge_detector
  import evm_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ID_W            = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] in,
  input  logic [1:0]      mode,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] pulse,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  output logic            conflict
);

  logic [N_CH-1:0] rise, fall, qual;
  logic [N_CH-1:0] pulse_q, pulse_d;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst_n   (reset),
      .in_i    (in[g]),
      .stable_o(level[g]),
      .rise_o  (rise[g]),
      .fall_o  (fall[g])
    );
  end

  // Keep only the transitions the current mode asks for.
  always_comb begin
    qual = '0;
    for (int i = 0; i < N_CH; i++) begin
      qual[i] = edge_qualify(mode, rise[i], fall[i]);
    end
  end

`ifdef EDGE_CONFLICT_GUARD_EN
  logic conflict_q, conflict_d;
  logic multi;

  // Suppress every pulse when two or more channels fire together.
  always_comb begin
    multi      = (qual & (qual - N_CH'(1))) != '0;
    pulse_d    = multi ? '0 : qual;
    conflict_d = multi;
  end

  // Conflict flag is registered so it lines up with the suppressed pulse slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict = conflict_q;
`else
  assign pulse_d  = qual;
  assign conflict = 1'b0;
`endif

  // Pulse register: one cycle per accepted qualified transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= pulse_d;
    end
  end

  // Priority encoder over the registered pulses: lowest index wins.
  always_comb begin
    evt_id = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pulse_q[i]) evt_id = ID_W'(i);
    end
  end

  assign pulse     = pulse_q;
  assign evt_valid = |pulse_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: directed scenarios plus random presses, with a
// windowed reference model compared against the DUT every cycle.
module tb_multi_edge_detector;
  import evm_pkg::*;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] in = '0;
  logic [1:0]   mode = EDGE_RISE;
  logic [N-1:0] level, pulse;
  logic         evt_valid, conflict;
  logic [1:0]   evt_id;

  logic         in1 = 1'b0;
  logic [1:0]   mode1 = EDGE_RISE;
  logic [0:0]   level1, pulse1, evt_id1;
  logic         evt_valid1, conflict1;

  int n_chk = 0;
  int n_bad = 0;
  int pc[N] = '{default: 0};

  multi_edge_detector #(.N_CH(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .in(in), .mode(mode), .level(level),
    .pulse(pulse), .evt_valid(evt_valid), .evt_id(evt_id), .conflict(conflict)
  );

  multi_edge_detector #(.N_CH(1), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .in(in1), .mode(mode1), .level(level1),
    .pulse(pulse1), .evt_valid(evt_valid1), .evt_id(evt_id1), .conflict(conflict1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Reference model: a change is accepted once the last D synchronised samples
  // all disagree with the current stable level.
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_pulse = '0;
  logic         m_conf = 1'b0;
  logic [N-1:0] hist[D] = '{default: '0};
  logic [N-1:0] m_acc, m_rise, m_fall, m_qual;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_pulse = '0; m_conf = 1'b0;
      for (int k = 0; k < D; k++) hist[k] = '0;
    end else begin
      for (int k = D - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = m_s2;
      m_acc = '1;
      for (int k = 0; k < D; k++) m_acc = m_acc & (hist[k] ^ m_stable);
      m_rise = m_acc & ~m_stable;
      m_fall = m_acc & m_stable;
      case (mode)
        2'b00:   m_qual = m_rise;
        2'b01:   m_qual = m_fall;
        2'b10:   m_qual = m_rise | m_fall;
        default: m_qual = '0;
      endcase
      m_stable = m_stable ^ m_acc;
`ifdef EDGE_CONFLICT_GUARD_EN
      m_conf  = $countones(m_qual) > 1;
      m_pulse = m_conf ? '0 : m_qual;
`else
      m_conf  = 1'b0;
      m_pulse = m_qual;
`endif
      m_s2 = m_s1;
      m_s1 = in;
    end
  end

  always @(negedge clk) begin
    check("level", 32'(level), 32'(m_stable));
    check("pulse", 32'(pulse), 32'(m_pulse));
    check("evt_valid", 32'(evt_valid), 32'(|m_pulse));
    check("evt_id", 32'(evt_id), 32'(lowest(m_pulse)));
    check("conflict", 32'(conflict), 32'(m_conf));
    for (int i = 0; i < N; i++) if (pulse[i]) pc[i]++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic measure(input int ch, output int lat);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #3;
      if (pulse[ch]) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int p0;
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int p0;
    tick(3);
    check("rst_level", 32'(level), 32'd0);
    check("rst_pulse", 32'(pulse), 32'd0);
    check("rst_evt_valid", 32'(evt_valid), 32'd0);
    check("rst_evt_id", 32'(evt_id), 32'd0);
    check("rst_conflict", 32'(conflict), 32'd0);
    reset = 1'b1;
    tick(3);

    // single press on channel 1, rising mode
    p0 = pc[1];
    in[1] = 1'b1;
    measure(1, lat);
    check("press_lat", 32'(lat), 32'd6);
    check("press_id", 32'(evt_id), 32'd1);
    check("press_valid", 32'(evt_valid), 32'd1);
    check("press_level", 32'(level[1]), 32'd1);
    tick(10);
    check("press_once", 32'(pc[1] - p0), 32'd1);
    in[1] = 1'b0;
    tick(10);

    // bounce on channel 0
    p0 = pc[0];
    in[0] = 1'b1; tick(3);
    in[0] = 1'b0; tick(3);
    in[0] = 1'b1; tick(3);
    in[0] = 1'b0; tick(3);
    in[0] = 1'b1;
    check("bounce_quiet", 32'(pc[0] - p0), 32'd0);
    measure(0, lat);
    check("bounce_lat", 32'(lat), 32'd6);
    tick(8);
    check("bounce_once", 32'(pc[0] - p0), 32'd1);

    // falling mode
    mode = EDGE_FALL;
    tick(2);
    p0 = pc[0];
    in[0] = 1'b0;
    measure(0, lat);
    check("fall_lat", 32'(lat), 32'd6);
    in[0] = 1'b1;
    tick(10);
    check("fall_only", 32'(pc[0] - p0), 32'd1);

    // both edges
    mode = EDGE_BOTH;
    p0 = pc[0];
    in[0] = 1'b0; tick(10);
    in[0] = 1'b1; tick(10);
    check("both_count", 32'(pc[0] - p0), 32'd2);

    // disabled: level still tracks
    mode = EDGE_OFF;
    p0 = pc[0];
    in[0] = 1'b0; tick(10);
    check("off_level_lo", 32'(level[0]), 32'd0);
    in[0] = 1'b1; tick(10);
    check("off_level_hi", 32'(level[0]), 32'd1);
    check("off_none", 32'(pc[0] - p0), 32'd0);
    in[0] = 1'b0;
    mode = EDGE_RISE;
    tick(10);

    // simultaneous presses on channels 2 and 3
    in[3:2] = 2'b11;
    tick(5);
    @(posedge clk);
    #3;
`ifdef EDGE_CONFLICT_GUARD_EN
    check("sim_pulse", 32'(pulse), 32'h0);
    check("sim_valid", 32'(evt_valid), 32'd0);
    check("sim_conflict", 32'(conflict), 32'd1);
`else
    check("sim_pulse", 32'(pulse), 32'hc);
    check("sim_id", 32'(evt_id), 32'd2);
    check("sim_valid", 32'(evt_valid), 32'd1);
`endif
    check("sim_level", 32'(level), 32'hc);
    @(posedge clk);
    #3;
    check("sim_after_pulse", 32'(pulse), 32'h0);
    check("sim_after_conf", 32'(conflict), 32'd0);
    in = '0;
    tick(10);

    // reset mid-debounce, input low at release
    in[1] = 1'b1;
    tick(4);
    reset = 1'b0;
    in[1] = 1'b0;
    tick(2);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_pulse", 32'(pulse), 32'd0);
    reset = 1'b1;
    p0 = pc[1];
    tick(10);
    check("midrst_none", 32'(pc[1] - p0), 32'd0);
    check("midrst_level2", 32'(level), 32'd0);

    // reset mid-debounce, input held high through release
    in[1] = 1'b1;
    tick(4);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    measure(1, lat);
    check("relhigh_lat", 32'(lat), 32'd6);
    tick(3);
    in[1] = 1'b0;
    tick(10);

    // single-channel, single-cycle debounce corner
    in1 = 1'b1;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #3;
      if (pulse1[0]) begin
        lat = c;
        break;
      end
    end
    check("n1_lat", 32'(lat), 32'd3);
    check("n1_id", 32'(evt_id1), 32'd0);
    check("n1_valid", 32'(evt_valid1), 32'd1);
    check("n1_level", 32'(level1), 32'd1);
    @(posedge clk);
    #3;
    check("n1_once", 32'(pulse1), 32'd0);
    check("n1_conflict", 32'(conflict1), 32'd0);
    in1 = 1'b0;
    tick(5);

    // random presses and mode changes
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int ch = 0; ch < N; ch++) begin
        if ($urandom_range(0, 5) == 0) in[ch] = ~in[ch];
      end
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      if (cyc == 700) reset = 1'b0;
      if (cyc == 702) reset = 1'b1;
      tick(1);
    end
    tick(12);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
